decoder_3to8: RTL and testbench
===============================

# decoder_3to8

Registered 3-to-8 one-hot decoder driven by three panel switches and driving eight LEDs. Exactly one LED output is high at all times, including during and after reset. The block sits between the switch input stage and the LED output stage of the panel-I/O path. An optional input synchronizer can be compiled in for asynchronous switch sources.

## Interface
- Parameters: none.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low; asserts immediately, releases synchronously to `clk`.
- `input_input_switch3_3`  in  1  select bit 2 (MSB).
- `input_input_switch1_1`  in  1  select bit 1.
- `input_input_switch2_2`  in  1  select bit 0 (LSB).
- `output_led1_0_4` … `output_led8_0_11`  out  1 each  one-hot outputs; `output_ledN` is high when the select value is N-1.
  - `output_led1_0_4` corresponds to select value 0.
  - `output_led8_0_11` corresponds to select value 7.

## Operation
- Select value: sel[2:0] = {switch3, switch1, switch2}. The bit order is not the order of the switch names; implement it exactly as listed.
- Decode: onehot[k] = (sel == k) for k = 0..7.
- Output register: onehot is loaded into an 8-bit output register every clock. The LED outputs are driven directly from register bits, with no combinational path from the inputs to the outputs.
- Invariant: the output register always holds exactly one set bit. Zero or multiple set bits is a design error.
- Reset: while `rst_n` is low, the output register is forced to 8'b0000_0001 (`output_led1_0_4`=1, all others 0). Any synchronizer stages are cleared to 0, so the first decoded value after release is also select value 0.
- Reset asserted mid-operation: the outputs go to the reset value asynchronously, without waiting for a clock edge. The previous select value is discarded.
- Input changes: there is no debounce or filtering. Every sampled value is decoded as-is.

## Timing
- Without synchronizer: latency is 1 cycle.
  - A select value present before rising edge n appears on the outputs after edge n.
- With synchronizer: latency is 3 cycles.
  - Two synchronizer stages are followed by the output register.
- Throughput: one new select value per cycle. No handshake and no stall.
- After `rst_n` deasserts:
  - Without synchronizer, the first edge loads the decode of the live inputs.
  - With synchronizer, the outputs stay at 8'b0000_0001 until the first sampled value reaches the output register.
- Glitch-free outputs: they change only on the rising edge of `clk` or on reset assertion.

## Configuration
- Macro: `DECODER_3TO8_SYNC_EN`.
- Defined:
  - Each of the three switch inputs passes through a 2-flop synchronizer, clocked by `clk` and reset to 0 by `rst_n`, before decode.
  - Latency is 3 cycles.
- Undefined:
  - The inputs are decoded directly into the output register.
  - Latency is 1 cycle.
- Port list and reset values are identical in both builds.

## Test plan
- Reset: drive `rst_n`=0 with inputs at 3'b111 → outputs = 8'b0000_0001 immediately, without a clock edge, and held for the whole reset.
- Exhaustive sweep:
  - For sel = 0..7, set {switch3, switch1, switch2}, then wait the build's latency in cycles.
  - Required: exactly one output high, and it is `output_led(sel+1)`. Examples: sel=5 → only `output_led6_0_9`=1; sel=7 → only `output_led8_0_11`=1.
- Bit-order check: switch2=1 only → `output_led2_0_5`=1; switch1=1 only → `output_led3_0_6`=1; switch3=1 only → `output_led5_0_8`=1.
- Latency: change sel from 0 to 6 just before an edge.
  - Without the macro: `output_led7_0_10` rises after exactly 1 edge.
  - With `DECODER_3TO8_SYNC_EN`: it rises after exactly 3 edges, and `output_led1_0_4` stays high until then.
- Mid-operation reset: hold sel=4 (`output_led5_0_8`=1), then pulse `rst_n` low between clock edges.
  - Outputs go to 8'b0000_0001 asynchronously.
  - After release, `output_led5_0_8` returns after the configured latency.
- Continuous one-hot: randomize the inputs every cycle for 1000 cycles → the popcount of the outputs equals 1 on every cycle.

Source files
------------

// File: rtl/decoder_3to8.sv
// decoder_3to8: registered 3-to-8 one-hot decoder from panel switches to LEDs.
// Define DECODER_3TO8_SYNC_EN to add a 2-flop synchronizer on each switch input.
module decoder_3to8 (
    input  logic clk,
    input  logic rst_n,
    input  logic input_input_switch3_3,
    input  logic input_input_switch1_1,
    input  logic input_input_switch2_2,
    output logic output_led1_0_4,
    output logic output_led2_0_5,
    output logic output_led3_0_6,
    output logic output_led4_0_7,
    output logic output_led5_0_8,
    output logic output_led6_0_9,
    output logic output_led7_0_10,
    output logic output_led8_0_11
);
    logic [2:0] sw;
    logic [2:0] sel;
    logic [7:0] led_d, led_q;

    // Switch names do not follow bit order: switch3 is the MSB, switch2 the LSB.
    assign sw = {input_input_switch3_3, input_input_switch1_1, input_input_switch2_2};

`ifdef DECODER_3TO8_SYNC_EN
    logic [2:0] sync1_d, sync1_q, sync2_d, sync2_q;

    always_comb begin
        sync1_d = sw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sel = sync2_q;
`else
    assign sel = sw;
`endif

    always_comb led_d = 8'b0000_0001 << sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led_q <= 8'b0000_0001;
        else        led_q <= led_d;
    end

    assign output_led1_0_4  = led_q[0];
    assign output_led2_0_5  = led_q[1];
    assign output_led3_0_6  = led_q[2];
    assign output_led4_0_7  = led_q[3];
    assign output_led5_0_8  = led_q[4];
    assign output_led6_0_9  = led_q[5];
    assign output_led7_0_10 = led_q[6];
    assign output_led8_0_11 = led_q[7];
endmodule

// File: tb/tb_decoder_3to8.sv
// tb_decoder_3to8: scoreboard bench for decoder_3to8 in either build.
module tb_decoder_3to8;
`ifdef DECODER_3TO8_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic s3 = 1'b0, s1 = 1'b0, s2 = 1'b0;
    logic o1, o2, o3, o4, o5, o6, o7, o8;
    logic [7:0] led;
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    assign led = {o8, o7, o6, o5, o4, o3, o2, o1};

    always #5 clk = ~clk;

    decoder_3to8 dut (
        .clk(clk), .rst_n(rst_n),
        .input_input_switch3_3(s3), .input_input_switch1_1(s1), .input_input_switch2_2(s2),
        .output_led1_0_4(o1), .output_led2_0_5(o2), .output_led3_0_6(o3), .output_led4_0_7(o4),
        .output_led5_0_8(o5), .output_led6_0_9(o6), .output_led7_0_10(o7), .output_led8_0_11(o8)
    );

    task automatic check(input string tag, input logic [7:0] exp);
        n_checks++;
        assert (led === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, led, exp);
        end
    endtask

    task automatic check_onehot(input string tag);
        n_checks++;
        assert ($countones(led) === 1) else begin
            n_fail++;
            $error("FAIL %s: observed popcount %0d expected 1 (led %b)", tag, $countones(led), led);
        end
    endtask

    task automatic drive(input logic [2:0] sel);
        s3 = sel[2];
        s1 = sel[1];
        s2 = sel[0];
    endtask

    task automatic step(input string tag, input logic [2:0] sel);
        logic [7:0] exp;
        @(negedge clk);
        drive(sel);
        exp_q.push_back(8'b0000_0001 << sel);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check(tag, exp);
        check_onehot(tag);
    endtask

    task automatic restart_scoreboard();
        exp_q.delete();
        for (int i = 0; i < LAT - 1; i++) exp_q.push_back(8'b0000_0001);
    endtask

    task automatic reset_pulse(input string tag, input int hold);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_async"}, 8'b0000_0001);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_held"}, 8'b0000_0001);
        end
        @(negedge clk);
        rst_n = 1'b1;
        restart_scoreboard();
    endtask

    initial begin
        drive(3'b111);
        repeat (2) @(posedge clk);
        reset_pulse("reset", 3);

        for (int k = 0; k < 8; k++)
            for (int j = 0; j < LAT; j++) step($sformatf("sweep_%0d", k), 3'(k));

        for (int j = 0; j < LAT; j++) step("bit_sw2", 3'b001);
        for (int j = 0; j < LAT; j++) step("bit_sw1", 3'b010);
        for (int j = 0; j < LAT; j++) step("bit_sw3", 3'b100);

        for (int j = 0; j < LAT + 1; j++) step("lat_zero", 3'd0);
        for (int j = 0; j < LAT + 1; j++) step("lat_six", 3'd6);

        for (int j = 0; j < LAT + 1; j++) step("pre_rst_sel4", 3'd4);
        reset_pulse("mid_rst", 1);
        for (int j = 0; j < LAT + 1; j++) step("post_rst_sel4", 3'd4);

        for (int c = 0; c < 1000; c++) step("random", 3'($urandom_range(0, 7)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
